spi_fifo_irq_ctrl: RTL and testbench



---
 rtl/spi_fifo_irq_ctrl_if.sv | 31 +++
 rtl/spi_fifo_irq_ctrl.sv | 83 ++++++++
 tb/tb_spi_fifo_irq_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_fifo_irq_ctrl_if.sv
// spi_fifo_irq_ctrl_if: signal bundle between the FIFO/APB side and spi_fifo_irq_ctrl.
// SPI_IRQ_LEVEL_EN adds the irq_level_o level-interrupt line.
interface spi_fifo_irq_ctrl_if #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 5
);
    logic                        clr_i;
    logic [NUM_CH*CNT_WIDTH-1:0] level_i;
    logic [NUM_CH-1:0]           xfer_i;
    logic [NUM_CH*CNT_WIDTH-1:0] th_i;
    logic [NUM_CH*CNT_WIDTH-1:0] cnt_i;
    logic [NUM_CH-1:0]           int_en_i;
    logic                        cnt_en_i;
    logic [NUM_CH-1:0]           ack_i;
    logic                        eot_i;
    logic [NUM_CH-1:0]           irq_pulse_o;
    logic [NUM_CH-1:0]           irq_sta_o;
    logic [1:0]                  events_o;
`ifdef SPI_IRQ_LEVEL_EN
    logic                        irq_level_o;
    modport master (output clr_i, level_i, xfer_i, th_i, cnt_i, int_en_i, cnt_en_i, ack_i, eot_i,
                    input irq_pulse_o, irq_sta_o, events_o, irq_level_o);
    modport slave (input clr_i, level_i, xfer_i, th_i, cnt_i, int_en_i, cnt_en_i, ack_i, eot_i,
                   output irq_pulse_o, irq_sta_o, events_o, irq_level_o);
`else
    modport master (output clr_i, level_i, xfer_i, th_i, cnt_i, int_en_i, cnt_en_i, ack_i, eot_i,
                    input irq_pulse_o, irq_sta_o, events_o);
    modport slave (input clr_i, level_i, xfer_i, th_i, cnt_i, int_en_i, cnt_en_i, ack_i, eot_i,
                   output irq_pulse_o, irq_sta_o, events_o);
`endif
endinterface

// File: rtl/spi_fifo_irq_ctrl.sv
// spi_fifo_irq_ctrl: per-channel FIFO-level interrupt generator with beat-count or ack re-arm.
// Optional SPI_IRQ_LEVEL_EN adds a registered level interrupt irq_level_o.
module spi_fifo_irq_ctrl #(
    parameter int                NUM_CH    = 2,
    parameter int                CNT_WIDTH = 5,
    parameter logic [NUM_CH-1:0] DIR_MASK  = NUM_CH'(2'b10)
) (
    input logic                HCLK,
    input logic                HRESETn,
    spi_fifo_irq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ACTIVE = 2'd0, GEN = 2'd1, INACTIVE = 2'd2} state_t;

    logic [NUM_CH-1:0] w_pulse;
    logic [NUM_CH-1:0] w_sta;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t               r_state;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 r_pulse;
        logic                 r_sta;
        logic [CNT_WIDTH-1:0] w_lvl;
        logic [CNT_WIDTH-1:0] w_th;
        logic [CNT_WIDTH-1:0] w_cnt;
        logic [CNT_WIDTH-1:0] w_last;
        logic                 w_rise;
        logic                 w_wrap;
        logic                 w_fire;

        assign w_lvl  = bus.level_i[c*CNT_WIDTH +: CNT_WIDTH];
        assign w_th   = bus.th_i[c*CNT_WIDTH +: CNT_WIDTH];
        assign w_cnt  = bus.cnt_i[c*CNT_WIDTH +: CNT_WIDTH];
        // a re-arm count of 0 behaves like 1: every beat wraps
        assign w_last = (w_cnt == '0) ? '0 : w_cnt - CNT_WIDTH'(1);
        assign w_rise = DIR_MASK[c] ? (w_lvl >= w_th) : (w_lvl <= w_th);
        assign w_wrap = bus.cnt_en_i && bus.xfer_i[c] && (r_cnt == w_last);
        assign w_fire = (r_state == ACTIVE) && w_rise && bus.int_en_i[c];

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                r_state <= ACTIVE;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
                r_sta   <= 1'b0;
            end else if (bus.clr_i) begin
                r_state <= ACTIVE;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
                r_sta   <= 1'b0;
            end else begin
                r_pulse <= w_fire;
                r_sta   <= w_fire | (r_sta & ~bus.ack_i[c]);
                r_cnt   <= !bus.cnt_en_i ? '0 :
                           !bus.xfer_i[c] ? r_cnt :
                           w_wrap ? '0 : r_cnt + CNT_WIDTH'(1);
                case (r_state)
                    ACTIVE:   r_state <= w_fire ? GEN : ACTIVE;
                    GEN:      r_state <= INACTIVE;
                    INACTIVE: r_state <= (bus.cnt_en_i ? w_wrap : bus.ack_i[c]) ? ACTIVE : INACTIVE;
                    default:  r_state <= ACTIVE;
                endcase
            end
        end

        assign w_pulse[c] = r_pulse;
        assign w_sta[c]   = r_sta;
    end

    assign bus.irq_pulse_o = w_pulse;
    assign bus.irq_sta_o   = w_sta;
    assign bus.events_o    = {bus.eot_i, |w_pulse};

`ifdef SPI_IRQ_LEVEL_EN
    logic r_level;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_level <= 1'b0;
        else          r_level <= |(w_sta & bus.int_en_i);
    end

    assign bus.irq_level_o = r_level;
`endif
endmodule

// File: tb/tb_spi_fifo_irq_ctrl.sv
// tb_spi_fifo_irq_ctrl: directed self-checking bench for spi_fifo_irq_ctrl (NUM_CH=2).
module tb_spi_fifo_irq_ctrl;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    spi_fifo_irq_ctrl_if #(.NUM_CH(2), .CNT_WIDTH(5)) bus ();

    spi_fifo_irq_ctrl #(.NUM_CH(2), .CNT_WIDTH(5), .DIR_MASK(2'b10)) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        bus.clr_i    = 1'b0;
        bus.level_i  = {5'd0, 5'd5};
        bus.th_i     = {5'd4, 5'd2};
        bus.cnt_i    = {5'd3, 5'd0};
        bus.xfer_i   = 2'b00;
        bus.int_en_i = 2'b00;
        bus.cnt_en_i = 1'b0;
        bus.ack_i    = 2'b00;
        bus.eot_i    = 1'b0;
        #12;
        chk("rst pulse", bus.irq_pulse_o, 2'b00);
        chk("rst sta", bus.irq_sta_o, 2'b00);
        chk("rst events", bus.events_o, 2'b00);
        bus.eot_i = 1'b1;
        #1;
        chk("rst eot passthru", bus.events_o, 2'b10);
        bus.eot_i = 1'b0;
        HRESETn = 1'b1;
        tick();
        // drain channel 0 fires once when level falls to threshold
        bus.int_en_i = 2'b01;
        bus.level_i  = {5'd0, 5'd3};
        tick();
        chk("ch0 above th", bus.irq_pulse_o, 2'b00);
        bus.level_i = {5'd0, 5'd2};
        tick();
        chk("ch0 pulse", bus.irq_pulse_o, 2'b01);
        chk("ch0 sta", bus.irq_sta_o, 2'b01);
        chk("ch0 event", bus.events_o, 2'b01);
        tick();
        chk("ch0 pulse one cycle", bus.irq_pulse_o, 2'b00);
        chk("ch0 sta sticky", bus.irq_sta_o, 2'b01);
        chk("ch0 event drop", bus.events_o, 2'b00);
        tick();
        tick();
        chk("ch0 no repulse", bus.irq_pulse_o, 2'b00);
        // ack re-arm: ack held two cycles so the second coincides with the fire
        bus.ack_i = 2'b01;
        tick();
        chk("ack rearm pulse", bus.irq_pulse_o, 2'b00);
        chk("ack clears sta", bus.irq_sta_o, 2'b00);
        tick();
        chk("rearm pulse", bus.irq_pulse_o, 2'b01);
        chk("set wins over ack", bus.irq_sta_o, 2'b01);
        bus.ack_i = 2'b00;
        tick();
        chk("inactive after gen", bus.irq_pulse_o, 2'b00);
        chk("sta held", bus.irq_sta_o, 2'b01);
        bus.ack_i    = 2'b01;
        bus.int_en_i = 2'b00;
        tick();
        bus.ack_i = 2'b00;
        tick();
        chk("disabled no fire", bus.irq_pulse_o, 2'b00);
        chk("sta acked", bus.irq_sta_o, 2'b00);
        // fill channel 1 re-armed every third beat
        bus.int_en_i = 2'b10;
        bus.cnt_en_i = 1'b1;
        bus.level_i  = {5'd4, 5'd2};
        tick();
        chk("ch1 fill pulse", bus.irq_pulse_o, 2'b10);
        chk("ch1 sta", bus.irq_sta_o, 2'b10);
        tick();
        chk("ch1 inactive", bus.irq_pulse_o, 2'b00);
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 3; b++) begin
                bus.xfer_i = 2'b10;
                tick();
                chk("ch1 beat quiet", bus.irq_pulse_o, 2'b00);
            end
            bus.xfer_i = 2'b00;
            tick();
            chk("ch1 count rearm", bus.irq_pulse_o, 2'b10);
            tick();
            chk("ch1 after rearm", bus.irq_pulse_o, 2'b00);
        end
        // count of 0 re-arms on every beat
        bus.cnt_i = {5'd0, 5'd0};
        for (int r = 0; r < 2; r++) begin
            bus.xfer_i = 2'b10;
            tick();
            chk("cnt0 beat", bus.irq_pulse_o, 2'b00);
            bus.xfer_i = 2'b00;
            tick();
            chk("cnt0 pulse", bus.irq_pulse_o, 2'b10);
            tick();
        end
        bus.level_i = {5'd3, 5'd2};
        bus.xfer_i  = 2'b10;
        tick();
        bus.xfer_i = 2'b00;
        tick();
        chk("ch1 below th", bus.irq_pulse_o, 2'b00);
        bus.level_i = {5'd4, 5'd2};
        tick();
        chk("ch1 at th", bus.irq_pulse_o, 2'b10);
        tick();
        // clr overrides a same-cycle fire, ack and beat
        bus.int_en_i = 2'b01;
        bus.clr_i    = 1'b1;
        bus.ack_i    = 2'b01;
        bus.xfer_i   = 2'b10;
        tick();
        chk("clr pulse", bus.irq_pulse_o, 2'b00);
        chk("clr sta", bus.irq_sta_o, 2'b00);
        bus.clr_i  = 1'b0;
        bus.ack_i  = 2'b00;
        bus.xfer_i = 2'b00;
        tick();
        chk("post clr fire", bus.irq_pulse_o, 2'b01);
        HRESETn = 1'b0;
        #1;
        chk("async rst pulse", bus.irq_pulse_o, 2'b00);
        chk("async rst sta", bus.irq_sta_o, 2'b00);
        HRESETn = 1'b1;
        tick();
        chk("post rst fire", bus.irq_pulse_o, 2'b01);
`ifdef SPI_IRQ_LEVEL_EN
        chk("level lag", {1'b0, bus.irq_level_o}, 2'b00);
        tick();
        chk("level set", {1'b0, bus.irq_level_o}, 2'b01);
        bus.int_en_i = 2'b00;
        tick();
        chk("level masked", {1'b0, bus.irq_level_o}, 2'b00);
`endif
        bus.eot_i = 1'b1;
        #1;
        chk("eot event", bus.events_o[1:1] == 1'b1 ? 2'b01 : 2'b00, 2'b01);
        bus.eot_i = 1'b0;
        #1;
        chk("eot event drop", {1'b0, bus.events_o[1]}, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
